// File: rtl/mem_rw_pkg.sv
// ----------------------------------------------------------------------------
// mem_rw_pkg
// Shared definitions for the burst read/write memory controller:
//   - state_t    : controller FSM encoding (IDLE, WR, RD, ERR)
//   - ERR_*      : error codes reported on o_err_code
// No ports; imported by mem_burst_sram and mem_burst_rw_ctrl.
// ----------------------------------------------------------------------------
package mem_rw_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    localparam logic [2:0] ERR_NONE   = 3'd0;
    localparam logic [2:0] ERR_RANGE  = 3'd1;
    localparam logic [2:0] ERR_ZLEN   = 3'd2;
    localparam logic [2:0] ERR_WR_TO  = 3'd3;
    localparam logic [2:0] ERR_RD_TO  = 3'd4;
    localparam logic [2:0] ERR_PARITY = 3'd5;

endpackage

// File: rtl/mem_burst_sram.sv
// ----------------------------------------------------------------------------
// mem_burst_sram
// Single-port DEPTH x DATA_W storage with a registered read port.
// Optional feature macro: MEM_BURST_PARITY_EN
//   defined   -> each word carries an extra even-parity bit written with the
//                data; o_par_err flags a parity mismatch on the addressed word
//   undefined -> storage is DATA_W wide and o_par_err is tied low
//
// Ports:
//   i_clk      clock, rising edge
//   i_reset    synchronous active-high reset (clears only the read register)
//   i_we       write enable: mem[i_addr] <= i_wdata
//   i_re       read enable: o_rdata <= mem[i_addr]
//   i_addr     shared word address
//   i_wdata    write data
//   o_rdata    registered read data, holds while i_re is low
//   o_par_err  parity mismatch on the word currently addressed
// ----------------------------------------------------------------------------
module mem_burst_sram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_par_err
);
    import mem_rw_pkg::*;

    localparam int DEPTH = 1 << ADDR_W;
`ifdef MEM_BURST_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif
    localparam int WORD_W = DATA_W + PAR_W;

    logic [WORD_W-1:0] mem [DEPTH];
    logic [WORD_W-1:0] wword;
    logic [WORD_W-1:0] rword;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;

    // The parity check looks at the addressed word before it is loaded, so a
    // corrupted word can be refused instead of being presented downstream.
    always_comb begin
        rword = mem[i_addr];
`ifdef MEM_BURST_PARITY_EN
        wword     = {^i_wdata, i_wdata};
        o_par_err = ^rword;
`else
        wword     = i_wdata;
        o_par_err = 1'b0;
`endif
        rdata_d = rdata_q;
        if (i_re) begin
            rdata_d = rword[DATA_W-1:0];
        end
    end

    // Storage is deliberately not reset: contents survive a controller reset.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_addr] <= wword;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign o_rdata = rdata_q;

endmodule

// File: rtl/mem_burst_rw_ctrl.sv
// ----------------------------------------------------------------------------
// mem_burst_rw_ctrl
// Single-port memory controller serving one write and one read burst channel.
// Round-robin arbitration, burst range/length checks, stall timeouts and a
// sticky error channel cleared by i_err_ack.
// Optional feature macro: MEM_BURST_PARITY_EN (per-word even parity, checked
// when the read register loads; mismatch aborts with code 5).
//
// Ports:
//   i_clk, i_reset              clock; synchronous active-high reset
//   i_wr_req / o_wr_ack         write burst request / one-cycle grant
//   i_wr_addr, i_wr_len         write burst start and beat count (sampled at ack)
//   i_wr_data, i_wr_valid       write beats, accepted every valid cycle in WR
//   o_wr_done                   pulse the cycle after the final write beat
//   i_rd_req / o_rd_ack         read burst request / one-cycle grant
//   i_rd_addr, i_rd_len         read burst start and beat count (sampled at ack)
//   o_rd_data, o_rd_valid       registered read beat, i_rd_ready handshake
//   o_rd_done                   pulse the cycle after the final read handshake
//   o_err, o_err_code, i_err_ack  sticky error report and acknowledge
// ----------------------------------------------------------------------------
module mem_burst_rw_ctrl #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 6,
    parameter int LEN_W   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_wr_req,
    output logic              o_wr_ack,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [LEN_W-1:0]  i_wr_len,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_wr_valid,
    output logic              o_wr_done,
    input  logic              i_rd_req,
    output logic              o_rd_ack,
    input  logic [ADDR_W-1:0] i_rd_addr,
    input  logic [LEN_W-1:0]  i_rd_len,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_rd_valid,
    input  logic              i_rd_ready,
    output logic              o_rd_done,
    output logic              o_err,
    output logic [2:0]        o_err_code,
    input  logic              i_err_ack
);
    import mem_rw_pkg::*;

    localparam int DEPTH   = 1 << ADDR_W;
    localparam int SUM_W   = ((ADDR_W > LEN_W) ? ADDR_W : LEN_W) + 1;
    localparam int STALL_W = $clog2(TIMEOUT + 1);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT - 1);
    localparam logic [SUM_W-1:0]   DEPTH_LIM  = SUM_W'(DEPTH);

    state_t              state_q, state_d;
    logic                wr_ack_q, wr_ack_d;
    logic                rd_ack_q, rd_ack_d;
    logic                wr_done_q, wr_done_d;
    logic                rd_done_q, rd_done_d;
    logic                rd_valid_q, rd_valid_d;
    logic                err_q, err_d;
    logic [2:0]          err_code_q, err_code_d;
    logic                last_rd_q, last_rd_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [LEN_W-1:0]    rem_q, rem_d;
    logic [STALL_W-1:0]  stall_q, stall_d;

    logic                sram_we;
    logic                sram_re;
    logic                par_err;
    logic [ADDR_W-1:0]   sel_addr;
    logic [LEN_W-1:0]    sel_len;
    logic [SUM_W-1:0]    burst_end;
    logic                rd_hs;
    logic                rd_load;

    mem_burst_sram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_sram (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_we      (sram_we),
        .i_re      (sram_re),
        .i_addr    (ptr_q),
        .i_wdata   (i_wr_data),
        .o_rdata   (o_rd_data),
        .o_par_err (par_err)
    );

    // Next-state logic. The grant is a two-step affair inside IDLE: the first
    // cycle registers the ack, the ack cycle itself samples addr/len, runs the
    // range/length check and leaves IDLE. The SRAM read register doubles as
    // o_rd_data, so read enable is only raised when a new beat may be shown.
    always_comb begin
        state_d    = state_q;
        wr_ack_d   = 1'b0;
        rd_ack_d   = 1'b0;
        wr_done_d  = 1'b0;
        rd_done_d  = 1'b0;
        rd_valid_d = rd_valid_q;
        err_d      = err_q;
        err_code_d = err_code_q;
        last_rd_d  = last_rd_q;
        ptr_d      = ptr_q;
        rem_d      = rem_q;
        stall_d    = stall_q;
        sram_we    = 1'b0;
        sram_re    = 1'b0;

        sel_addr  = rd_ack_q ? i_rd_addr : i_wr_addr;
        sel_len   = rd_ack_q ? i_rd_len  : i_wr_len;
        burst_end = SUM_W'(sel_addr) + SUM_W'(sel_len);
        rd_hs     = rd_valid_q && i_rd_ready;
        rd_load   = (!rd_valid_q || i_rd_ready) && (rem_q != '0);

        case (state_q)
            ST_IDLE: begin
                if (wr_ack_q || rd_ack_q) begin
                    ptr_d   = sel_addr;
                    rem_d   = sel_len;
                    stall_d = '0;
                    if (sel_len == '0) begin
                        state_d    = ST_ERR;
                        err_d      = 1'b1;
                        err_code_d = ERR_ZLEN;
                    end else if (burst_end > DEPTH_LIM) begin
                        state_d    = ST_ERR;
                        err_d      = 1'b1;
                        err_code_d = ERR_RANGE;
                    end else if (wr_ack_q) begin
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_RD;
                    end
                end else if (i_wr_req && (!i_rd_req || last_rd_q)) begin
                    // Contention goes to the channel that did not win last.
                    wr_ack_d  = 1'b1;
                    last_rd_d = 1'b0;
                end else if (i_rd_req) begin
                    rd_ack_d  = 1'b1;
                    last_rd_d = 1'b1;
                end
            end

            ST_WR: begin
                if (i_wr_valid) begin
                    sram_we = 1'b1;
                    ptr_d   = ptr_q + ADDR_W'(1);
                    rem_d   = rem_q - LEN_W'(1);
                    stall_d = '0;
                    if (rem_q == LEN_W'(1)) begin
                        wr_done_d = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end else if (stall_q == STALL_LAST) begin
                    state_d    = ST_ERR;
                    err_d      = 1'b1;
                    err_code_d = ERR_WR_TO;
                    stall_d    = '0;
                end else begin
                    stall_d = stall_q + STALL_W'(1);
                end
            end

            ST_RD: begin
                if (rd_hs) begin
                    rd_valid_d = 1'b0;
                end
                if (rd_load) begin
                    if (par_err) begin
                        // A corrupted word is never presented.
                        state_d    = ST_ERR;
                        err_d      = 1'b1;
                        err_code_d = ERR_PARITY;
                        rd_valid_d = 1'b0;
                    end else begin
                        sram_re    = 1'b1;
                        rd_valid_d = 1'b1;
                        ptr_d      = ptr_q + ADDR_W'(1);
                        rem_d      = rem_q - LEN_W'(1);
                    end
                end else if (rd_hs) begin
                    // Handshake with nothing left to issue: final beat taken.
                    rd_done_d = 1'b1;
                    state_d   = ST_IDLE;
                end

                if (rd_valid_q && !i_rd_ready) begin
                    if (stall_q == STALL_LAST) begin
                        state_d    = ST_ERR;
                        err_d      = 1'b1;
                        err_code_d = ERR_RD_TO;
                        rd_valid_d = 1'b0;
                        stall_d    = '0;
                    end else begin
                        stall_d = stall_q + STALL_W'(1);
                    end
                end else begin
                    stall_d = '0;
                end
            end

            ST_ERR: begin
                if (i_err_ack) begin
                    state_d    = ST_IDLE;
                    err_d      = 1'b0;
                    err_code_d = ERR_NONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // After reset the last grant counts as read so that write wins first.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            wr_ack_q   <= 1'b0;
            rd_ack_q   <= 1'b0;
            wr_done_q  <= 1'b0;
            rd_done_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            last_rd_q  <= 1'b1;
            ptr_q      <= '0;
            rem_q      <= '0;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            wr_ack_q   <= wr_ack_d;
            rd_ack_q   <= rd_ack_d;
            wr_done_q  <= wr_done_d;
            rd_done_q  <= rd_done_d;
            rd_valid_q <= rd_valid_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            last_rd_q  <= last_rd_d;
            ptr_q      <= ptr_d;
            rem_q      <= rem_d;
            stall_q    <= stall_d;
        end
    end

    assign o_wr_ack   = wr_ack_q;
    assign o_rd_ack   = rd_ack_q;
    assign o_wr_done  = wr_done_q;
    assign o_rd_done  = rd_done_q;
    assign o_rd_valid = rd_valid_q;
    assign o_err      = err_q;
    assign o_err_code = err_code_q;

endmodule

// File: tb/tb_mem_burst_rw_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mem_burst_rw_ctrl
// Directed testbench for mem_burst_rw_ctrl: bursts, arbitration, error
// checks, stall timeouts, read backpressure and reset during a burst.
// The parity scenario is compiled only with MEM_BURST_PARITY_EN defined.
// ----------------------------------------------------------------------------
module tb_mem_burst_rw_ctrl;

    localparam int DATA_W  = 8;
    localparam int ADDR_W  = 6;
    localparam int LEN_W   = 4;
    localparam int TIMEOUT = 16;

    logic              i_clk = 1'b0;
    logic              i_reset;
    logic              i_wr_req;
    logic              o_wr_ack;
    logic [ADDR_W-1:0] i_wr_addr;
    logic [LEN_W-1:0]  i_wr_len;
    logic [DATA_W-1:0] i_wr_data;
    logic              i_wr_valid;
    logic              o_wr_done;
    logic              i_rd_req;
    logic              o_rd_ack;
    logic [ADDR_W-1:0] i_rd_addr;
    logic [LEN_W-1:0]  i_rd_len;
    logic [DATA_W-1:0] o_rd_data;
    logic              o_rd_valid;
    logic              i_rd_ready;
    logic              o_rd_done;
    logic              o_err;
    logic [2:0]        o_err_code;
    logic              i_err_ack;

    int checks   = 0;
    int failures = 0;
    int wr_ack_seen  = 0;
    int wr_done_seen = 0;
    logic [7:0] model_mem [64];
    logic [7:0] rd_buf [16];

    mem_burst_rw_ctrl #(
        .DATA_W (DATA_W), .ADDR_W (ADDR_W), .LEN_W (LEN_W), .TIMEOUT (TIMEOUT)
    ) dut (
        .i_clk      (i_clk),      .i_reset    (i_reset),
        .i_wr_req   (i_wr_req),   .o_wr_ack   (o_wr_ack),
        .i_wr_addr  (i_wr_addr),  .i_wr_len   (i_wr_len),
        .i_wr_data  (i_wr_data),  .i_wr_valid (i_wr_valid),
        .o_wr_done  (o_wr_done),
        .i_rd_req   (i_rd_req),   .o_rd_ack   (o_rd_ack),
        .i_rd_addr  (i_rd_addr),  .i_rd_len   (i_rd_len),
        .o_rd_data  (o_rd_data),  .o_rd_valid (o_rd_valid),
        .i_rd_ready (i_rd_ready), .o_rd_done  (o_rd_done),
        .o_err      (o_err),      .o_err_code (o_err_code),
        .i_err_ack  (i_err_ack)
    );

    always #5 i_clk = ~i_clk;

    // Pulse counters sampled on the falling edge, away from register updates.
    always @(negedge i_clk) begin
        if (o_wr_ack === 1'b1)  wr_ack_seen++;
        if (o_wr_done === 1'b1) wr_done_seen++;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_wr_req = 1'b0; i_wr_addr = '0; i_wr_len = '0; i_wr_data = '0; i_wr_valid = 1'b0;
        i_rd_req = 1'b0; i_rd_addr = '0; i_rd_len = '0; i_rd_ready = 1'b0; i_err_ack = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        i_reset = 1'b1;
        tick();
        tick();
        i_reset = 1'b0;
    endtask

    // Full write burst; returns in the cycle where o_wr_done should be high.
    task automatic run_write(input int addr, input int len, input logic [7:0] first, input logic [7:0] step);
        i_wr_req = 1'b1; i_wr_addr = 6'(addr); i_wr_len = 4'(len);
        tick();
        i_wr_req = 1'b0;
        tick();
        for (int i = 0; i < len; i++) begin
            i_wr_valid = 1'b1;
            i_wr_data  = first + step * 8'(i);
            model_mem[addr + i] = i_wr_data;
            tick();
        end
        i_wr_valid = 1'b0;
    endtask

    // Full read burst with ready high; beats land in rd_buf, returns in the done cycle.
    task automatic run_read(input int addr, input int len);
        i_rd_req = 1'b1; i_rd_addr = 6'(addr); i_rd_len = 4'(len);
        tick();
        i_rd_req = 1'b0; i_rd_ready = 1'b1;
        tick();
        for (int i = 0; i < len; i++) begin
            tick();
            rd_buf[i] = o_rd_data;
        end
        tick();
        i_rd_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if ({o_wr_ack, o_rd_ack, o_wr_done, o_rd_done} !== 4'b0) begin failures++;
            $display("[TB] FAIL reset_acks_dones: got %b want 0000", {o_wr_ack, o_rd_ack, o_wr_done, o_rd_done}); end
        checks++; if (o_rd_valid !== 1'b0 || o_rd_data !== 8'h00) begin failures++;
            $display("[TB] FAIL reset_rd: got valid=%b data=%h want 0/00", o_rd_valid, o_rd_data); end
        checks++; if (o_err !== 1'b0 || o_err_code !== 3'd0) begin failures++;
            $display("[TB] FAIL reset_err: got err=%b code=%0d want 0/0", o_err, o_err_code); end
    endtask

    task automatic test_write_read();
        wr_ack_seen = 0;
        i_wr_req = 1'b1; i_wr_addr = 6'd4; i_wr_len = 4'd3;
        tick();
        checks++; if (o_wr_ack !== 1'b1) begin failures++;
            $display("[TB] FAIL wr_ack: got %b want 1", o_wr_ack); end
        i_wr_req = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            i_wr_valid = 1'b1; i_wr_data = 8'hA1 + 8'(i);
            model_mem[4 + i] = i_wr_data;
            tick();
            if (i < 2) begin
                checks++; if (o_wr_done !== 1'b0) begin failures++;
                    $display("[TB] FAIL wr_done_early beat %0d: got %b want 0", i, o_wr_done); end
            end
        end
        i_wr_valid = 1'b0;
        checks++; if (o_wr_done !== 1'b1) begin failures++;
            $display("[TB] FAIL wr_done: got %b want 1", o_wr_done); end
        tick();
        checks++; if (o_wr_done !== 1'b0 || wr_ack_seen != 1) begin failures++;
            $display("[TB] FAIL wr_done_pulse: done=%b acks=%0d want 0/1", o_wr_done, wr_ack_seen); end

        i_rd_req = 1'b1; i_rd_addr = 6'd4; i_rd_len = 4'd3;
        tick();
        checks++; if (o_rd_ack !== 1'b1) begin failures++;
            $display("[TB] FAIL rd_ack: got %b want 1", o_rd_ack); end
        i_rd_req = 1'b0; i_rd_ready = 1'b1;
        tick();
        checks++; if (o_rd_valid !== 1'b0) begin failures++;
            $display("[TB] FAIL rd_latency: valid=%b one cycle after ack, want 0", o_rd_valid); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (o_rd_valid !== 1'b1 || o_rd_data !== 8'hA1 + 8'(i)) begin failures++;
                $display("[TB] FAIL rd_beat %0d: got valid=%b data=%h want 1/%h", i, o_rd_valid, o_rd_data, 8'hA1 + 8'(i)); end
        end
        tick();
        checks++; if (o_rd_done !== 1'b1 || o_rd_valid !== 1'b0) begin failures++;
            $display("[TB] FAIL rd_done: got done=%b valid=%b want 1/0", o_rd_done, o_rd_valid); end
        i_rd_ready = 1'b0;
        tick();
    endtask

    task automatic test_arbitration();
        do_reset();
        i_wr_req = 1'b1; i_wr_addr = 6'd20; i_wr_len = 4'd1;
        i_rd_req = 1'b1; i_rd_addr = 6'd4;  i_rd_len = 4'd1;
        tick();
        checks++; if (o_wr_ack !== 1'b1 || o_rd_ack !== 1'b0) begin failures++;
            $display("[TB] FAIL arb_first: got wr_ack=%b rd_ack=%b want 1/0", o_wr_ack, o_rd_ack); end
        i_wr_req = 1'b0;
        tick();
        i_wr_valid = 1'b1; i_wr_data = 8'h33; model_mem[20] = 8'h33;
        tick();
        i_wr_valid = 1'b0;
        checks++; if (o_wr_done !== 1'b1 || o_rd_ack !== 1'b0) begin failures++;
            $display("[TB] FAIL arb_wait: got wr_done=%b rd_ack=%b want 1/0", o_wr_done, o_rd_ack); end
        tick();
        checks++; if (o_rd_ack !== 1'b1) begin failures++;
            $display("[TB] FAIL arb_rd_after_done: got rd_ack=%b want 1", o_rd_ack); end
        i_rd_req = 1'b0; i_rd_ready = 1'b1;
        tick();
        tick();
        checks++; if (o_rd_valid !== 1'b1 || o_rd_data !== 8'hA1) begin failures++;
            $display("[TB] FAIL arb_rd_data: got valid=%b data=%h want 1/a1", o_rd_valid, o_rd_data); end
        tick();
        i_rd_ready = 1'b0;

        // A lone write makes write the last grant, so contention now favours read.
        run_write(30, 1, 8'h44, 8'h00);
        i_wr_req = 1'b1; i_wr_addr = 6'd31; i_wr_len = 4'd1;
        i_rd_req = 1'b1; i_rd_addr = 6'd20; i_rd_len = 4'd1;
        tick();
        checks++; if (o_rd_ack !== 1'b1 || o_wr_ack !== 1'b0) begin failures++;
            $display("[TB] FAIL arb_second: got rd_ack=%b wr_ack=%b want 1/0", o_rd_ack, o_wr_ack); end
        i_rd_req = 1'b0; i_rd_ready = 1'b1;
        tick();
        tick();
        checks++; if (o_rd_data !== 8'h33) begin failures++;
            $display("[TB] FAIL arb_rd2_data: got %h want 33", o_rd_data); end
        tick();
        tick();
        i_rd_ready = 1'b0;
        checks++; if (o_wr_ack !== 1'b1) begin failures++;
            $display("[TB] FAIL arb_wr_after_rd: got wr_ack=%b want 1", o_wr_ack); end
        i_wr_req = 1'b0;
        tick();
        i_wr_valid = 1'b1; i_wr_data = 8'h55; model_mem[31] = 8'h55;
        tick();
        i_wr_valid = 1'b0;
        tick();
    endtask

    task automatic test_errors();
        run_write(62, 2, 8'h77, 8'h01);
        checks++; if (o_wr_done !== 1'b1 || o_err !== 1'b0) begin failures++;
            $display("[TB] FAIL range_edge_ok: got done=%b err=%b want 1/0", o_wr_done, o_err); end
        tick();

        i_wr_req = 1'b1; i_wr_addr = 6'd62; i_wr_len = 4'd3;
        i_wr_valid = 1'b1; i_wr_data = 8'hEE;
        tick();
        i_wr_req = 1'b0; i_err_ack = 1'b1;
        tick();
        i_err_ack = 1'b0;
        checks++; if (o_err !== 1'b1 || o_err_code !== 3'd1) begin failures++;
            $display("[TB] FAIL range_err: got err=%b code=%0d want 1/1", o_err, o_err_code); end
        tick();
        tick();
        checks++; if (o_err !== 1'b1 || o_err_code !== 3'd1) begin failures++;
            $display("[TB] FAIL err_hold: got err=%b code=%0d want 1/1", o_err, o_err_code); end
        i_wr_valid = 1'b0; i_err_ack = 1'b1;
        tick();
        i_err_ack = 1'b0;
        checks++; if (o_err !== 1'b0 || o_err_code !== 3'd0) begin failures++;
            $display("[TB] FAIL err_clear: got err=%b code=%0d want 0/0", o_err, o_err_code); end
        run_read(62, 2);
        checks++; if (rd_buf[0] !== 8'h77 || rd_buf[1] !== 8'h78) begin failures++;
            $display("[TB] FAIL range_no_write: got %h %h want 77 78", rd_buf[0], rd_buf[1]); end
        tick();

        i_rd_req = 1'b1; i_rd_addr = 6'd5; i_rd_len = 4'd0;
        tick();
        i_rd_req = 1'b0;
        i_wr_req = 1'b1; i_wr_addr = 6'd40; i_wr_len = 4'd1;
        tick();
        checks++; if (o_err !== 1'b1 || o_err_code !== 3'd2) begin failures++;
            $display("[TB] FAIL zlen_err: got err=%b code=%0d want 1/2", o_err, o_err_code); end
        tick();
        checks++; if (o_wr_ack !== 1'b0) begin failures++;
            $display("[TB] FAIL err_blocks_grant: got wr_ack=%b want 0", o_wr_ack); end
        i_err_ack = 1'b1;
        tick();
        i_err_ack = 1'b0;
        tick();
        checks++; if (o_wr_ack !== 1'b1) begin failures++;
            $display("[TB] FAIL req_kept_through_err: got wr_ack=%b want 1", o_wr_ack); end
        i_wr_req = 1'b0;
        tick();
        i_wr_valid = 1'b1; i_wr_data = 8'h5C; model_mem[40] = 8'h5C;
        tick();
        i_wr_valid = 1'b0;
        tick();
    endtask

    task automatic test_write_stall();
        i_wr_req = 1'b1; i_wr_addr = 6'd8; i_wr_len = 4'd2;
        tick();
        i_wr_req = 1'b0;
        repeat (TIMEOUT) tick();
        checks++; if (o_err !== 1'b0) begin failures++;
            $display("[TB] FAIL wr_stall_early: got err=%b after 15 stalls want 0", o_err); end
        tick();
        checks++; if (o_err !== 1'b1 || o_err_code !== 3'd3) begin failures++;
            $display("[TB] FAIL wr_timeout: got err=%b code=%0d want 1/3", o_err, o_err_code); end
        i_err_ack = 1'b1;
        tick();
        i_err_ack = 1'b0;
        tick();
    endtask

    task automatic test_read_stall();
        int bad;
        bad = 0;
        i_rd_req = 1'b1; i_rd_addr = 6'd40; i_rd_len = 4'd2; i_rd_ready = 1'b0;
        tick();
        i_rd_req = 1'b0;
        tick();
        tick();
        for (int k = 0; k < TIMEOUT; k++) begin
            if (o_rd_valid !== 1'b1 || o_rd_data !== 8'h5C) bad++;
            if (k != TIMEOUT - 1) tick();
        end
        checks++; if (bad != 0 || o_err !== 1'b0) begin failures++;
            $display("[TB] FAIL rd_stall_hold: unstable=%0d err=%b want 0/0", bad, o_err); end
        tick();
        checks++; if (o_err !== 1'b1 || o_err_code !== 3'd4 || o_rd_valid !== 1'b0) begin failures++;
            $display("[TB] FAIL rd_timeout: got err=%b code=%0d valid=%b want 1/4/0", o_err, o_err_code, o_rd_valid); end
        i_err_ack = 1'b1;
        tick();
        i_err_ack = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        int idx;
        logic prev_stall;
        logic [7:0] prev_data;
        logic done_seen;
        idx = 0; prev_stall = 1'b0; prev_data = '0; done_seen = 1'b0;
        run_write(48, 4, 8'h11, 8'h11);
        tick();
        i_rd_req = 1'b1; i_rd_addr = 6'd48; i_rd_len = 4'd4;
        tick();
        i_rd_req = 1'b0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (o_rd_done === 1'b1) begin
                done_seen = 1'b1;
                break;
            end
            if (prev_stall) begin
                checks++; if (o_rd_valid !== 1'b1 || o_rd_data !== prev_data) begin failures++;
                    $display("[TB] FAIL bp_stable: got valid=%b data=%h want 1/%h", o_rd_valid, o_rd_data, prev_data); end
            end
            i_rd_ready = (cyc % 2 == 0);
            if (o_rd_valid === 1'b1 && i_rd_ready) begin
                checks++; if (idx > 3 || o_rd_data !== model_mem[48 + idx]) begin failures++;
                    $display("[TB] FAIL bp_beat %0d: got %h want %h", idx, o_rd_data, model_mem[48 + (idx & 3)]); end
                idx++;
            end
            prev_stall = (o_rd_valid === 1'b1) && !i_rd_ready;
            prev_data  = o_rd_data;
            tick();
        end
        i_rd_ready = 1'b0;
        checks++; if (!done_seen || idx != 4) begin failures++;
            $display("[TB] FAIL bp_count: got done=%b beats=%0d want 1/4", done_seen, idx); end
        tick();
    endtask

    task automatic test_reset_mid_burst();
        i_wr_req = 1'b1; i_wr_addr = 6'd0; i_wr_len = 4'd4;
        tick();
        i_wr_req = 1'b0;
        tick();
        i_wr_valid = 1'b1; i_wr_data = 8'h99; model_mem[0] = 8'h99;
        tick();
        i_wr_valid = 1'b0; i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        checks++; if ({o_wr_ack, o_rd_ack, o_wr_done, o_rd_done, o_rd_valid, o_err, o_err_code, o_rd_data} !== 17'b0) begin failures++;
            $display("[TB] FAIL midreset_outputs: got %h want 0", {o_wr_ack, o_rd_ack, o_wr_done, o_rd_done, o_rd_valid, o_err, o_err_code, o_rd_data}); end
        wr_done_seen = 0;
        repeat (4) tick();
        checks++; if (wr_done_seen != 0 || o_err !== 1'b0) begin failures++;
            $display("[TB] FAIL midreset_quiet: got dones=%0d err=%b want 0/0", wr_done_seen, o_err); end
        run_read(0, 1);
        checks++; if (rd_buf[0] !== 8'h99) begin failures++;
            $display("[TB] FAIL midreset_mem0: got %h want 99", rd_buf[0]); end
        run_read(48, 1);
        checks++; if (rd_buf[0] !== 8'h11) begin failures++;
            $display("[TB] FAIL midreset_mem48: got %h want 11", rd_buf[0]); end
        tick();
    endtask

`ifdef MEM_BURST_PARITY_EN
    task automatic test_parity();
        run_write(10, 1, 8'hC3, 8'h00);
        tick();
        dut.u_sram.mem[10][8] = ~dut.u_sram.mem[10][8];
        i_rd_req = 1'b1; i_rd_addr = 6'd10; i_rd_len = 4'd1; i_rd_ready = 1'b1;
        tick();
        i_rd_req = 1'b0;
        tick();
        tick();
        checks++; if (o_rd_valid !== 1'b0 || o_err !== 1'b1 || o_err_code !== 3'd5) begin failures++;
            $display("[TB] FAIL parity: got valid=%b err=%b code=%0d want 0/1/5", o_rd_valid, o_err, o_err_code); end
        i_rd_ready = 1'b0; i_err_ack = 1'b1;
        tick();
        i_err_ack = 1'b0;
        tick();
    endtask
`endif

    initial begin
        i_reset = 1'b1;
        idle_inputs();
        test_reset();
        test_write_read();
        test_arbitration();
        test_errors();
        test_write_stall();
        test_read_stall();
        test_backpressure();
        test_reset_mid_burst();
`ifdef MEM_BURST_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_burst_rw_ctrl.md
# mem_burst_rw_ctrl

Parametrised single-port memory controller that serves one write channel and one read channel with burst transfers. It arbitrates between the channels round-robin and checks every burst for address range, length and stalls. Faults are reported on an error channel that holds until acknowledged. It sits between the command front-end and on-chip storage.

## Interface
- DATA_W, 8, data beat width
- ADDR_W, 6, word address width; DEPTH = 2**ADDR_W
- LEN_W, 4, burst length field width (beats)
- TIMEOUT, 16, consecutive stall cycles tolerated before abort
- i_clk  in  1  clock; all logic on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_wr_req  in  1  write burst request, held until o_wr_ack
- o_wr_ack  out  1  one-cycle grant; addr/len sampled this cycle
- i_wr_addr  in  ADDR_W  burst start address
- i_wr_len  in  LEN_W  beat count; 0 illegal
- i_wr_data  in  DATA_W  write beat
- i_wr_valid  in  1  beat present; always accepted in WR
- o_wr_done  out  1  one-cycle pulse after last beat
- i_rd_req  in  1  read burst request, held until o_rd_ack
- o_rd_ack  out  1  one-cycle grant; addr/len sampled this cycle
- i_rd_addr  in  ADDR_W  burst start address
- i_rd_len  in  LEN_W  beat count; 0 illegal
- o_rd_data  out  DATA_W  read beat, stable while o_rd_valid && !i_rd_ready
- o_rd_valid  out  1  beat present
- i_rd_ready  in  1  consumer accepts beat
- o_rd_done  out  1  one-cycle pulse after last beat handshake
- o_err  out  1  error pending, held until i_err_ack
- o_err_code  out  3  1 range, 2 zero-len, 3 wr timeout, 4 rd timeout, 5 parity
- i_err_ack  in  1  clears the error

## Operation
- States: IDLE, WR, RD, ERR.
- IDLE:
  - Grant one pending request and pulse the matching ack.
  - When both are pending, grant opposite the last grant. After reset the last grant counts as read, so write wins first.
  - Latch the address into a pointer and the length into a remaining-beat counter.
- Request check, done in the grant cycle:
  - len==0 -> ERR, code 2.
  - addr+len > DEPTH, computed at ADDR_W+1 bits -> ERR, code 1.
  - Otherwise -> WR or RD. No wrap-around is ever performed.
- WR:
  - Each i_wr_valid cycle writes mem[ptr], increments ptr and decrements remaining.
  - After the final beat: o_wr_done pulses next cycle and the state returns to IDLE.
- RD:
  - o_rd_data/o_rd_valid is a registered output. It loads mem[ptr] when (!o_rd_valid || i_rd_ready) and beats remain to issue.
  - Full throughput: one beat per cycle while i_rd_ready is held high.
  - After the final handshake: o_rd_done pulses and the state returns to IDLE.
- Stall timer:
  - Counts consecutive cycles with !i_wr_valid in WR, or o_rd_valid && !i_rd_ready in RD.
  - Clears on any progress.
  - Reaching TIMEOUT aborts -> ERR, code 3 or 4. o_rd_valid drops in the same transition.
- ERR:
  - o_err=1 and o_err_code hold. Requests are not granted.
  - i_err_ack -> IDLE, with o_err and o_err_code cleared next cycle.
- Requests that stay high while ERR or a burst is active wait; they are never dropped.

## Timing
- Reset value 0 for: o_wr_ack, o_rd_ack, o_wr_done, o_rd_valid, o_rd_done, o_err, o_err_code, o_rd_data. State becomes IDLE.
- Reset mid-burst:
  - Aborts the burst with no done pulse and no error.
  - Memory contents are not cleared.
- Ack timing: ack appears the cycle after req is seen in IDLE (registered).
- Write: the first beat is accepted the cycle after the ack.
- Read: first o_rd_valid is 2 cycles after the ack cycle.
- Done pulses: the cycle after the final write beat or final read handshake.
- Back-to-back: the next ack is at the earliest the cycle after done.
- i_err_ack arriving in the same cycle the error is raised is ignored.

## Configuration
- MEM_BURST_PARITY_EN defined:
  - Each word stores an extra even-parity bit, written with the data.
  - The bit is checked when the read register loads.
  - On mismatch that beat is not presented, the burst aborts and the state goes to ERR with code 5.
- MEM_BURST_PARITY_EN undefined:
  - Storage is DATA_W only.
  - Code 5 is never produced.

## Structure
- Package mem_rw_pkg holds:
  - the state encoding;
  - the error code constants ERR_NONE, ERR_RANGE, ERR_ZLEN, ERR_WR_TO, ERR_RD_TO, ERR_PARITY.
- Sub-module mem_burst_sram:
  - single-port DEPTH x (DATA_W+parity) array;
  - write enable;
  - synchronous read into a register;
  - parity bit is generate-conditional on MEM_BURST_PARITY_EN.

## Test plan
- Write burst: addr=4, len=3, data 0xA1,0xA2,0xA3 -> one o_wr_ack, o_wr_done one cycle after 0xA3. Then read burst addr=4, len=3 with ready=1 -> 0xA1,0xA2,0xA3 on consecutive cycles, o_rd_done after the third.
- Simultaneous req after reset -> write granted first, read granted after o_wr_done. Simultaneous req again -> read granted first.
- Range and length errors:
  - addr=62, len=3 -> ERR code 1, no memory write.
  - len=0 -> code 2.
  - i_err_ack -> o_err=0 next cycle.
- Stalls:
  - Write stall: no i_wr_valid for 16 cycles -> code 3.
  - Read stall: ready low for 16 cycles with data 0x5C held stable -> code 4, o_rd_valid drops.
- Read backpressure: ready toggling 1,0,1,0 over len=4 -> every beat delivered once, in order, data stable while stalled.
- Parity (MEM_BURST_PARITY_EN): force a parity bit flip in mem[10], read addr=10 len=1 -> no o_rd_valid, ERR code 5. i_reset mid-burst -> all outputs 0, no done pulse.
